// File: rtl/ram_stream_reader.sv
// Streams `count` consecutive RAM words from `base` onto a valid/ready port.
// Define RAM_STREAM_READER_LOOP_EN to replay the pass until `stop`.
`timescale 1ns/1ps
module ram_stream_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base,
  input  logic [ADDRESS_WIDTH:0]   count,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = 1;

  logic [1:0]               state_reg;
  logic                     done_reg;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [ADDRESS_WIDTH:0]   remaining_reg;
`ifdef RAM_STREAM_READER_LOOP_EN
  logic [ADDRESS_WIDTH-1:0] base_reg;
  logic [ADDRESS_WIDTH:0]   count_reg;
`endif

  logic                     inflight_reg;
  logic                     inflight_last_reg;
  logic [DATA_WIDTH-1:0]    fifo_data [2];
  logic                     fifo_last [2];
  logic                     wr_ptr_reg;
  logic                     rd_ptr_reg;
  logic [1:0]               occ_reg;

  logic pop;
  logic flush;
  logic issue;
  logic issue_last;
  logic end_pass;

  // Issue only if the word will have a FIFO slot, counting this cycle's pop.
  always_comb begin
    pop        = out_valid & out_ready;
    flush      = (state_reg == RUN) & stop;
    issue      = (state_reg == RUN) && !stop && (remaining_reg != '0) &&
                 (({1'b0, occ_reg} + {2'b00, inflight_reg}) <= (3'd1 + {2'b00, pop}));
    issue_last = (remaining_reg == CNT_ONE);
`ifdef RAM_STREAM_READER_LOOP_EN
    end_pass   = flush;
`else
    end_pass   = flush | (pop & out_last);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      done_reg      <= 1'b0;
      addr_reg      <= '0;
      remaining_reg <= '0;
`ifdef RAM_STREAM_READER_LOOP_EN
      base_reg      <= '0;
      count_reg     <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state_reg     <= RUN;
              addr_reg      <= base;
              remaining_reg <= count;
`ifdef RAM_STREAM_READER_LOOP_EN
              base_reg      <= base;
              count_reg     <= count;
`endif
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (end_pass) begin
            state_reg <= FINISH;
            done_reg  <= 1'b1;
          end
        end
        FINISH:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (issue) begin
`ifdef RAM_STREAM_READER_LOOP_EN
        if (issue_last) begin
          remaining_reg <= count_reg;
          addr_reg      <= base_reg;
        end else
`endif
        begin
          remaining_reg <= remaining_reg - CNT_ONE;
          addr_reg      <= addr_reg + ADDR_ONE;
        end
      end
    end
  end

  // The RAM answers one cycle after the address is presented; capture then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      occ_reg           <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      inflight_reg      <= issue;
      inflight_last_reg <= issue_last;
      if (flush) begin
        occ_reg    <= 2'd0;
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
      end else begin
        if (inflight_reg) begin
          fifo_data[wr_ptr_reg] <= ram_dataOut;
          fifo_last[wr_ptr_reg] <= inflight_last_reg;
          wr_ptr_reg            <= ~wr_ptr_reg;
        end
        if (pop) rd_ptr_reg <= ~rd_ptr_reg;
        occ_reg <= occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
      end
    end
  end

  assign busy      = (state_reg == RUN);
  assign done      = done_reg;
  assign ram_wEn   = 1'b0;
  assign ram_addr  = addr_reg;
  assign out_valid = (occ_reg != 2'd0);
  assign out_data  = fifo_data[rd_ptr_reg];
  assign out_last  = out_valid & fifo_last[rd_ptr_reg];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader: a RAM model feeds the DUT and a
// per-pass word queue built from mem[] predicts the stream.
`timescale 1ns/1ps
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] base = 8'h00;
  logic [8:0] count = 9'd0;
  logic       busy, done, ram_wEn, out_valid, out_last;
  logic [7:0] ram_addr, out_data;
  logic [7:0] ram_dataOut = 8'h00;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_dataOut <= mem[ram_addr];

  ram_stream_reader #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
    .stop(stop), .busy(busy), .done(done), .ram_wEn(ram_wEn),
    .ram_addr(ram_addr), .ram_dataOut(ram_dataOut), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // One pass from `b` of `n` words; the expected stream is mem[b+i] in order,
  // repeated every n words when the reader loops.
  task automatic run_pass(input logic [7:0] b, input int n, input int ready_pct,
                          input int stop_at, input int restart_at, input bit periodic);
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    int total, budget;
    int first_cycle, last_cycle, done_cycle, n_xfer, stall_run;
    bit stall_prev, must_stream, stopped, timing;
    logic [7:0] held;
    total = periodic ? 60 : n;
    budget = 20 * n + 60;
    first_cycle = -1; last_cycle = -1; done_cycle = -1; n_xfer = 0; stall_run = 0;
    stall_prev = 0; must_stream = 0; stopped = 0; held = 8'h00;
    timing = (ready_pct >= 100) && (stop_at == 0) && !periodic;
    for (int i = 0; i < total; i++) begin
      exp_data.push_back(mem[8'(int'(b) + (i % n))]);
      exp_last.push_back((i % n) == (n - 1));
    end
    @(posedge clk); #1;
    start = 1'b1; base = b; count = 9'(n); stop = 1'b0; out_ready = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      if (start) begin base = ~b; count = 9'd5; end
      stop = (c == stop_at);
      out_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < ready_pct);
      @(negedge clk);
      if (c == 1) begin
        check("busy_start", busy, 1);
        check("addr_first", ram_addr, b);
      end
      if (timing && c < 3) check("valid_early", out_valid, 0);
      if (stopped) check("valid_after_stop", out_valid, 0);
      if (out_valid && stall_prev) check("stall_hold", out_data, held);
      if (out_ready) begin
        if (stall_run >= 3) must_stream = 1;
        stall_run = 0;
      end else begin
        must_stream = 0;
        if (out_valid) stall_run++;
      end
      if (must_stream && exp_data.size() > 0 && !stopped) check("no_bubble", out_valid, 1);
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) check("extra_word", out_valid, 0);
        else begin
          check("data", out_data, exp_data.pop_front());
          check("last", out_last, exp_last.pop_front());
        end
        n_xfer++;
        if (first_cycle < 0) first_cycle = c;
        last_cycle = c;
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
      if (stop) stopped = 1;
      if (done) begin
        done_cycle = c;
        check("busy_at_done", busy, 0);
        break;
      end
    end
    stop = 1'b0; start = 1'b0; out_ready = 1'b1;
    check("done_seen", 32'(done_cycle > 0), 1);
    if (done_cycle > 0) begin
      if (timing) begin
        check("first_cycle", first_cycle, 3);
        check("last_cycle", last_cycle, n + 2);
        check("done_cycle", done_cycle, n + 3);
      end
      if (stop_at > 0) begin
        check("stop_done_cycle", done_cycle, stop_at + 1);
        if (ready_pct >= 100) check("xfers_before_stop", n_xfer, stop_at - 2);
      end else begin
        check("words_left", exp_data.size(), 0);
      end
    end
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    if (restart_at > 0) begin
      @(negedge clk);
      check("restart_ignored", busy, 0);
    end
    $display("pass base=0x%02h count=%0d ready=%0d%% stop_at=%0d words=%0d done_cycle=%0d",
             b, n, ready_pct, stop_at, n_xfer, done_cycle);
  endtask

  task automatic zero_count_pass();
    @(posedge clk); #1;
    start = 1'b1; base = 8'($urandom); count = 9'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_valid", out_valid, 0);
    @(negedge clk);
    check("zero_done_pulse", done, 0);
    check("zero_valid2", out_valid, 0);
    $display("pass count=0 done=1 cycle after start");
  endtask

  task automatic reset_mid_pass();
    @(posedge clk); #1;
    start = 1'b1; base = 8'h40; count = 9'd16; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", ram_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_no_done", done, 0);
    check("rst_valid_after", out_valid, 0);
    check("rst_busy_after", busy, 0);
    $display("reset mid-pass: outputs cleared, no done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", out_valid, 0);
    check("reset_last", out_last, 0);
    check("reset_data", out_data, 0);
    check("reset_addr", ram_addr, 0);
    check("reset_wen", ram_wEn, 0);
`ifdef RAM_STREAM_READER_LOOP_EN
    run_pass(8'h20, 3, 100, 14, 0, 1);
    run_pass(8'hFF, 3, 70, 30, 0, 1);
    run_pass(8'($urandom), 16, 100, 5, 0, 0);
    reset_mid_pass();
`else
    run_pass(8'h10, 4, 100, 0, 0, 0);
    run_pass(8'hFE, 4, 100, 0, 0, 0);
    for (int k = 0; k < 3; k++) run_pass(8'($urandom), 8, 50, 0, 0, 0);
    run_pass(8'($urandom), 16, 60, 0, 0, 0);
    run_pass(8'h80, 256, 100, 0, 0, 0);
    zero_count_pass();
    run_pass(8'h33, 6, 100, 0, 2, 0);
    run_pass(8'($urandom), 16, 100, 5, 0, 0);
    reset_mid_pass();
    run_pass(8'($urandom), 5, 100, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      run_pass(8'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(30, 100)), 0, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
